// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, a single-entry holding register
// and one-cycle framing/overrun error pulses.
module uart_rx #(
    parameter int OVS_DIV     = 27,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_main,
    input  logic       reset,
    input  logic       rx_line,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       framing_err,
    output logic       overrun_err,
    output logic       rx_busy
);

    localparam int TW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(OVS_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [TW-1:0]          tick_cnt;
    logic                   tick;
    logic [3:0]             smp_cnt;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_q;
    logic                   shift_en;
    logic                   frame_ok;
    logic                   frame_bad;

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign tick    = (state_q != IDLE) && (tick_cnt == TICK_MAX);
    assign rx_busy = (state_q != IDLE);

    // Preset to 1 so reset never looks like a start bit on an idle line.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_line};
        end
    end

    always_ff @(posedge clk_main) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_en  = 1'b0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) state_d = START;
            end
            START: begin
                // Mid start bit: a high line here was only a glitch.
                if (tick && smp_cnt == 4'd7) begin
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && smp_cnt == 4'd15) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (tick && smp_cnt == 4'd15) begin
                    if (rx_s) begin
                        frame_ok = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_main) begin
        if (reset) begin
            tick_cnt <= '0;
            smp_cnt  <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
        end else begin
            if (state_q == IDLE || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            if (state_d != state_q) begin
                smp_cnt <= '0;
            end else if (tick) begin
                smp_cnt <= smp_cnt + 4'd1;
            end
            if (state_q != DATA) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (shift_en) begin
                shift_q <= {rx_s, shift_q[7:1]};
            end
        end
    end

    // A completed byte is dropped, not queued, when the holder is still full.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            framing_err <= frame_bad;
            overrun_err <= frame_ok && rx_valid && !rx_ready;
            if (frame_ok && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at OVS_DIV=4 (64 clks per bit):
// vector table for plain frames, hand sequences for the corner cases.
module tb_uart_rx;

    localparam int OVS = 4;
    localparam int BIT = 16 * OVS;

    logic       clk_main = 1'b0;
    logic       reset    = 1'b1;
    logic       rx_line  = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_err;
    logic       overrun_err;
    logic       rx_busy;

    uart_rx #(.OVS_DIV(OVS), .SYNC_STAGES(2)) dut (
        .clk_main    (clk_main),
        .reset       (reset),
        .rx_line     (rx_line),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
        .rx_busy     (rx_busy)
    );

    always #5 clk_main = ~clk_main;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int hs_cnt   = 0;
    int ferr_cnt = 0;
    int oerr_cnt = 0;
    int rise_cnt = 0;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         bit_clks;
        int         exp_hs;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk_main) cyc++;

    // Inputs change at posedge+1, so at negedge both sides are settled.
    always @(negedge clk_main) begin
        if (!reset) begin
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    check("hs_unexpected", {24'h0, rx_data}, 32'hffff_ffff);
                end else begin
                    check("hs_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
                end
                hs_cnt++;
            end
            if (framing_err) ferr_cnt++;
            if (overrun_err) oerr_cnt++;
            if (rx_valid && !prev_valid) rise_cnt++;
            prev_valid = rx_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk_main);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx_line = b;
        repeat (n) step();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bc);
        drive_bit(1'b0, bc);
        for (int i = 0; i < 8; i++) drive_bit(d[i], bc);
        drive_bit(stop, bc);
        rx_line = 1'b1;
    endtask

    task automatic wait_valid(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (rx_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic pulse_ready();
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, {24'h0, rx_data}, 32'h0);
        check({tag, "_valid"}, {31'h0, rx_valid}, 32'h0);
        check({tag, "_ferr"}, {31'h0, framing_err}, 32'h0);
        check({tag, "_oerr"}, {31'h0, overrun_err}, 32'h0);
        check({tag, "_busy"}, {31'h0, rx_busy}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, f0, o0, r0, c0, lat, n;
        bit ok, saw, done;

        vecs[0] = '{8'h00, 1'b1, 64, 1, 0};
        vecs[1] = '{8'hFF, 1'b1, 64, 1, 0};
        vecs[2] = '{8'hA5, 1'b1, 64, 1, 0};
        vecs[3] = '{8'h5A, 1'b1, 63, 1, 0};
        vecs[4] = '{8'h81, 1'b1, 65, 1, 0};
        vecs[5] = '{8'hC3, 1'b1, 63, 1, 0};
        vecs[6] = '{8'h3E, 1'b1, 65, 1, 0};
        vecs[7] = '{8'h7E, 1'b0, 64, 0, 1};

        repeat (5) step();
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (5) step();

        // Single frame, no consumer: latency and held data.
        h0 = hs_cnt; f0 = ferr_cnt; o0 = oerr_cnt;
        c0 = cyc;
        fork
            send_frame(8'hD3, 1'b1, BIT);
            wait_valid(1000, ok);
        join_any
        lat = cyc - c0;
        check("d3_valid_seen", {31'h0, ok}, 32'h1);
        check("d3_latency_range", {31'h0, (lat >= 608 && lat <= 616)}, 32'h1);
        check("d3_data", {24'h0, rx_data}, 32'hD3);
        wait fork;
        repeat (10) step();
        check("d3_still_valid", {31'h0, rx_valid}, 32'h1);
        check("d3_errors", ferr_cnt - f0 + oerr_cnt - o0, 0);
        exp_q.push_back(8'hD3);
        pulse_ready();
        step();
        check("d3_hs", hs_cnt - h0, 1);
        check("d3_cleared", {31'h0, rx_valid}, 32'h0);

        // Back-to-back frames with a consumer pulsing ready.
        h0 = hs_cnt; o0 = oerr_cnt;
        exp_q.push_back(8'hD3);
        exp_q.push_back(8'hF0);
        fork
            begin
                send_frame(8'hD3, 1'b1, BIT);
                send_frame(8'hF0, 1'b1, BIT);
            end
            begin
                wait_valid(1500, ok);
                check("b2b_first_seen", {31'h0, ok}, 32'h1);
                pulse_ready();
                step();
                wait_valid(1500, ok);
                check("b2b_second_seen", {31'h0, ok}, 32'h1);
                pulse_ready();
            end
        join
        repeat (20) step();
        check("b2b_hs", hs_cnt - h0, 2);
        check("b2b_oerr", oerr_cnt - o0, 0);
        check("b2b_queue", exp_q.size(), 0);

        // Table: ready held high, each frame drains through the scoreboard.
        rx_ready = 1'b1;
        foreach (vecs[k]) begin
            h0 = hs_cnt; f0 = ferr_cnt; o0 = oerr_cnt;
            if (vecs[k].exp_hs != 0) exp_q.push_back(vecs[k].data);
            send_frame(vecs[k].data, vecs[k].stop, vecs[k].bit_clks);
            repeat (20) step();
            check($sformatf("vec%0d_hs", k), hs_cnt - h0, vecs[k].exp_hs);
            check($sformatf("vec%0d_ferr", k), ferr_cnt - f0, vecs[k].exp_ferr);
            check($sformatf("vec%0d_oerr", k), oerr_cnt - o0, 0);
            check($sformatf("vec%0d_busy", k), {31'h0, rx_busy}, 32'h0);
            check($sformatf("vec%0d_queue", k), exp_q.size(), 0);
        end

        // Low stop bit held into a break, then a good frame.
        h0 = hs_cnt; f0 = ferr_cnt; r0 = rise_cnt;
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_bit(n_checks[31], BIT);
        rx_line = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rx_line = (8'hF0 >> i) & 1;
        end
        rx_line = 1'b0;
        repeat (BIT + 100) step();
        rx_line = 1'b1;
        repeat (20) step();
        check("brk_ferr", ferr_cnt - f0, 1);
        check("brk_no_valid", rise_cnt - r0, 0);
        check("brk_busy", {31'h0, rx_busy}, 32'h0);
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1, BIT);
        repeat (20) step();
        check("brk_next_hs", hs_cnt - h0, 1);

        // Short glitch on an idle line.
        f0 = ferr_cnt; r0 = rise_cnt; o0 = oerr_cnt;
        n = 0; saw = 0; done = 0;
        rx_line = 1'b0;
        while (n < 60 && !done) begin
            step();
            n++;
            if (n == 20) rx_line = 1'b1;
            if (rx_busy) saw = 1'b1;
            else if (saw) done = 1'b1;
        end
        check("glitch_busy_seen", {31'h0, saw}, 32'h1);
        check("glitch_idle_within_40", {31'h0, (done && n <= 40)}, 32'h1);
        repeat (700) step();
        check("glitch_no_valid", rise_cnt - r0, 0);
        check("glitch_no_err", ferr_cnt - f0 + oerr_cnt - o0, 0);

        // Overrun: second byte lost, first held.
        rx_ready = 1'b0;
        o0 = oerr_cnt; r0 = rise_cnt; h0 = hs_cnt;
        send_frame(8'h55, 1'b1, BIT);
        send_frame(8'hAA, 1'b1, BIT);
        repeat (20) step();
        check("ovr_oerr", oerr_cnt - o0, 1);
        check("ovr_data", {24'h0, rx_data}, 32'h55);
        check("ovr_valid", {31'h0, rx_valid}, 32'h1);
        check("ovr_rises", rise_cnt - r0, 1);
        exp_q.push_back(8'h55);
        pulse_ready();
        step();
        check("ovr_hs", hs_cnt - h0, 1);

        // Reset in the middle of bit 4.
        f0 = ferr_cnt; o0 = oerr_cnt; r0 = rise_cnt;
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive_bit((8'hC5 >> i) & 1, BIT);
        drive_bit(1'b0, BIT / 2);
        rx_line = 1'b1;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        check_reset_outputs("midrst");
        repeat (700) step();
        check("midrst_no_valid", rise_cnt - r0, 0);
        check("midrst_no_err", ferr_cnt - f0 + oerr_cnt - o0, 0);
        h0 = hs_cnt;
        rx_ready = 1'b1;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, BIT);
        repeat (20) step();
        check("midrst_next_hs", hs_cnt - h0, 1);
        check("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
